buc_sched: RTL and testbench
============================

# buc_sched

Two-requester scheduler and serializer for the `buc` serial threshold detector. Each requester supplies 11-bit codewords and its own 4-bit threshold. The block arbitrates round-robin and shifts the granted word MSB-first onto `din`, switching `threshold` per word. It attributes each detector `valid` pulse back to the requester that owns the bit stream, so several producers can share one detector with gap-free back-to-back framing.

## Interface
- `WORD_W`, 11: codeword width in bits.
- `THR_W`, 4: threshold width.
- `DET_LAT`, 1: cycles from `din` bit to the detector `valid` it causes; legal range 1..8.
- `CNT_W`, 8: hit counter width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a word.
- `req0_data` in WORD_W: requester 0 codeword.
- `req0_thr` in THR_W: requester 0 threshold, sampled at accept.
- `req0_ready` out 1: requester 0 word accepted this cycle (combinational).
- `req1_valid`, `req1_data`, `req1_thr`, `req1_ready`: same as requester 0, for requester 1.
- `din` out 1: registered serial bit to the detector.
- `threshold` out THR_W: registered threshold to the detector.
- `frame` out 1: high while `din` carries a codeword bit.
- `owner` out 1: requester owning the current `din` bit.
- `det_valid` in 1: detector `valid` output.
- `hit0` out CNT_W: saturating count of `det_valid` pulses attributed to requester 0.
- `hit1` out CNT_W: same, for requester 1.
- `hit_clr` in 1: synchronous clear of both counters.

## Operation
- States: IDLE, SHIFT.
- Accept window: the state is IDLE, or the state is SHIFT and the bit counter is 0 (last bit on `din`).
- Arbitration in the accept window:
  - Only one valid requester: grant it.
  - Both valid: grant the requester not granted last time. The pointer resets to prefer requester 0.
  - The granted requester's `ready` goes high for exactly that cycle. At most one `ready` is high per cycle.
- On accept:
  - Shift register ← data, counter ← WORD_W-1, `threshold` ← thr, `owner` ← grant, `frame` ← 1.
  - The state becomes or stays SHIFT.
- In SHIFT:
  - `din` = shift register MSB (the register output drives it directly).
  - Each cycle: shift left, decrement the counter.
  - At counter 0 with no accept: next state IDLE, `frame` ← 0, `din` ← 0, and `threshold` and `owner` hold.
- Attribution:
  - An owner/frame history shift register DET_LAT deep delays (`owner`, `frame`).
  - `det_valid` increments `hit0` or `hit1` according to the delayed owner, only when the delayed frame is 1.
  - `det_valid` with delayed frame 0 is ignored.
- Counters saturate at all-ones.
- `hit_clr` has priority over an increment in the same cycle; the result is 0.
- Requester inputs are sampled only in the cycle `ready` is high. Data may change freely otherwise.
- Reset mid-word: the word is discarded and not resumed. No `ready` is asserted while `rst` is low.

## Timing
- Reset values: `din`=0, `threshold`=0, `frame`=0, `owner`=0, `hit0`=`hit1`=0, history cleared, state IDLE, pointer → requester 0.
- Accept at cycle t:
  - `din` = bit WORD_W-1 at t+1, through bit 0 at t+WORD_W.
  - `threshold`/`owner` valid from t+1.
- Back-to-back: an accept at t+WORD_W makes the next MSB appear at t+WORD_W+1 with no gap. `threshold` switches exactly at the first bit of the new word.
- Detector pulse for a bit at cycle c arrives at c+DET_LAT. The counter updates at c+DET_LAT+1.
- Throughput: one word per WORD_W cycles when inputs are continuously valid.

## Test plan
- Reset then single word on req0: data 11100010011, thr 1001, `req0_valid` held.
  - `req0_ready` is high one cycle.
  - `din` shows 1,1,1,0,0,0,1,0,0,1,1 on the next 11 cycles.
  - `frame` is high for exactly 11 cycles; `threshold`=1001.
- Continuous req0 stream of three words (11100010011, 11100010001, 11100010010) → 33 contiguous `din` bits with no gap, matching a 33-bit concatenation MSB-first.
- Both requesters always valid:
  - Grants alternate 0,1,0,1.
  - `threshold` alternates thr0/thr1 on the first bit of each word.
  - Never two `ready` in one cycle.
- Drive `det_valid` with DET_LAT=1:
  - A pulse one cycle after a req1 bit increments only `hit1`.
  - A pulse while the delayed frame is 0 changes nothing.
  - 300 pulses leave `hit1`=255; `hit_clr` together with a pulse → 0.
- Assert `rst` low at bit 5 of a word:
  - All outputs return to reset values immediately.
  - After release, the next accept starts a fresh word.
  - The round-robin pointer prefers req0.

Source files
------------

// File: rtl/buc_sched.sv
// buc_sched: two-requester round-robin scheduler and MSB-first serializer
// feeding a shared buc threshold detector, with per-requester hit
// attribution through a DET_LAT-deep owner/frame history.
module buc_sched #(
   parameter int unsigned WORD_W  = 11,
   parameter int unsigned THR_W   = 4,
   parameter int unsigned DET_LAT = 1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [WORD_W-1:0] req0_data,
   input  logic [THR_W-1:0]  req0_thr,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WORD_W-1:0] req1_data,
   input  logic [THR_W-1:0]  req1_thr,
   output logic              req1_ready,
   output logic              din,
   output logic [THR_W-1:0]  threshold,
   output logic              frame,
   output logic              owner,
   input  logic              det_valid,
   output logic [CNT_W-1:0]  hit0,
   output logic [CNT_W-1:0]  hit1,
   input  logic              hit_clr
);

   localparam int unsigned CNT_BITS = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state_q;
   logic [WORD_W-1:0]   sr_q;
   logic [CNT_BITS-1:0] cnt_q;
   logic [THR_W-1:0]    thr_q;
   logic                owner_q;
   logic                frame_q;
   logic                last_q;
   logic [DET_LAT-1:0]  hist_own_q;
   logic [DET_LAT-1:0]  hist_frm_q;
   logic [CNT_W-1:0]    hit0_q;
   logic [CNT_W-1:0]    hit1_q;
   logic [CNT_W-1:0]    hit0_d;
   logic [CNT_W-1:0]    hit1_d;

   logic                accept_win;
   logic                accept_d;
   logic                grant_d;
   logic [WORD_W-1:0]   sel_data;
   logic [THR_W-1:0]    sel_thr;
   logic                own_dly;
   logic                frm_dly;

   // Accept window and round-robin grant selection.
   always_comb begin
      accept_win = (state_q == IDLE) || (cnt_q == '0);
      if (req0_valid && req1_valid) begin
         grant_d = ~last_q;
      end else begin
         grant_d = req1_valid;
      end
      accept_d = accept_win && (req0_valid || req1_valid);
      sel_data = grant_d ? req1_data : req0_data;
      sel_thr  = grant_d ? req1_thr  : req0_thr;
   end

   // Ready is suppressed while reset is held so nothing is handed over then.
   assign req0_ready = rst && accept_d && !grant_d;
   assign req1_ready = rst && accept_d &&  grant_d;

   // Serializer FSM: load on accept, shift MSB-first, drop frame after bit 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         thr_q   <= '0;
         owner_q <= 1'b0;
         frame_q <= 1'b0;
         last_q  <= 1'b1;   // first tie goes to requester 0
      end else if (accept_d) begin
         state_q <= SHIFT;
         sr_q    <= sel_data;
         cnt_q   <= CNT_BITS'(WORD_W - 1);
         thr_q   <= sel_thr;
         owner_q <= grant_d;
         frame_q <= 1'b1;
         last_q  <= grant_d;
      end else if (state_q == SHIFT) begin
         if (cnt_q == '0) begin
            state_q <= IDLE;
            sr_q    <= '0;
            frame_q <= 1'b0;
         end else begin
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Owner/frame history aligning each detector pulse with the bit that caused it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_own_q <= '0;
         hist_frm_q <= '0;
      end else begin
         hist_own_q <= DET_LAT'({hist_own_q, owner_q});
         hist_frm_q <= DET_LAT'({hist_frm_q, frame_q});
      end
   end

   assign own_dly = hist_own_q[DET_LAT-1];
   assign frm_dly = hist_frm_q[DET_LAT-1];

   // Saturating hit counters; clear wins over a same-cycle increment.
   always_comb begin
      hit0_d = hit0_q;
      hit1_d = hit1_q;
      if (hit_clr) begin
         hit0_d = '0;
         hit1_d = '0;
      end else if (det_valid && frm_dly) begin
         if (own_dly) begin
            if (hit1_q != '1) hit1_d = hit1_q + 1'b1;
         end else begin
            if (hit0_q != '1) hit0_d = hit0_q + 1'b1;
         end
      end
   end

   // Hit counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit0_q <= '0;
         hit1_q <= '0;
      end else begin
         hit0_q <= hit0_d;
         hit1_q <= hit1_d;
      end
   end

   assign din       = sr_q[WORD_W-1];
   assign threshold = thr_q;
   assign frame     = frame_q;
   assign owner     = owner_q;
   assign hit0      = hit0_q;
   assign hit1      = hit1_q;

endmodule

// File: tb/tb_buc_sched.sv
// Testbench for buc_sched: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based model.
module tb_buc_sched;

   localparam int W  = 11;
   localparam int TW = 4;
   localparam int DL = 1;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [W-1:0]  req0_data = '0, req1_data = '0;
   logic [TW-1:0] req0_thr = '0, req1_thr = '0;
   logic          req0_ready, req1_ready;
   logic          din, frame, owner;
   logic [TW-1:0] threshold;
   logic          det_valid = 1'b0, hit_clr = 1'b0;
   logic [CW-1:0] hit0, hit1;

   always #5 clk = ~clk;

   buc_sched #(.WORD_W(W), .THR_W(TW), .DET_LAT(DL), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_thr(req0_thr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_thr(req1_thr), .req1_ready(req1_ready),
      .din(din), .threshold(threshold), .frame(frame), .owner(owner),
      .det_valid(det_valid), .hit0(hit0), .hit1(hit1), .hit_clr(hit_clr)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic          b;
      logic          o;
      logic [TW-1:0] t;
   } bit_t;

   bit_t          mq[$];      // bits still to appear on din
   logic          hf[$];      // frame history, DL deep
   logic          ho[$];      // owner history, DL deep
   logic          m_last, m_din, m_frame, m_owner;
   logic [TW-1:0] m_thr;
   int            m_hit0, m_hit1;

   function automatic void model_reset();
      mq.delete();
      hf.delete();
      ho.delete();
      for (int i = 0; i < DL; i++) begin
         hf.push_back(1'b0);
         ho.push_back(1'b0);
      end
      m_last  = 1'b1;
      m_din   = 1'b0;
      m_frame = 1'b0;
      m_owner = 1'b0;
      m_thr   = '0;
      m_hit0  = 0;
      m_hit1  = 0;
   endfunction

   task automatic chk_outputs();
      chk("din", din, m_din);
      chk("frame", frame, m_frame);
      chk("owner", owner, m_owner);
      chk("threshold", threshold, m_thr);
      chk("hit0", hit0, m_hit0);
      chk("hit1", hit1, m_hit1);
   endtask

   // One clock: drive inputs, check readies, clock, advance model, check outputs.
   task automatic step(input logic v0, input logic [W-1:0] d0, input logic [TW-1:0] t0,
                       input logic v1, input logic [W-1:0] d1, input logic [TW-1:0] t1,
                       input logic dv, input logic clr,
                       output logic r0, output logic r1);
      logic acc, g, df, dow;
      req0_valid = v0; req0_data = d0; req0_thr = t0;
      req1_valid = v1; req1_data = d1; req1_thr = t1;
      det_valid  = dv; hit_clr  = clr;
      #1;
      acc = (mq.size() == 0) && (v0 || v1);
      g   = (v0 && v1) ? !m_last : v1;
      r0  = req0_ready;
      r1  = req1_ready;
      chk("req0_ready", r0, acc && !g);
      chk("req1_ready", r1, acc && g);
      @(posedge clk);
      df  = hf.pop_front();
      dow = ho.pop_front();
      if (clr) begin
         m_hit0 = 0;
         m_hit1 = 0;
      end else if (dv && df) begin
         if (dow) m_hit1 = (m_hit1 < 255) ? m_hit1 + 1 : 255;
         else     m_hit0 = (m_hit0 < 255) ? m_hit0 + 1 : 255;
      end
      hf.push_back(m_frame);
      ho.push_back(m_owner);
      if (acc) begin
         m_last = g;
         for (int i = W - 1; i >= 0; i--) begin
            bit_t e;
            e.b = g ? d1[i] : d0[i];
            e.o = g;
            e.t = g ? t1 : t0;
            mq.push_back(e);
         end
      end
      if (mq.size() > 0) begin
         bit_t e;
         e = mq.pop_front();
         m_din   = e.b;
         m_frame = 1'b1;
         m_owner = e.o;
         m_thr   = e.t;
      end else begin
         m_din   = 1'b0;
         m_frame = 1'b0;
      end
      #1;
      chk_outputs();
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0; det_valid = 1'b0; hit_clr = 1'b0;
      rst = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          v0;
      logic [W-1:0]  d0;
      logic [TW-1:0] t0;
      logic          e_r0;
      logic          e_din;
      logic          e_frame;
      logic [TW-1:0] e_thr;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          r0, r1;
      logic [W-1:0]  w0;
      logic [W-1:0]  wd[3];
      logic [32:0]   cap, exp33;
      int            idx, nbits;
      logic          started;
      int            gq[$];

      w0 = 11'b11100010011;
      for (int k = 0; k < 13; k++) begin
         tbl[k].v0      = (k < 10);
         tbl[k].d0      = (k == 0) ? w0 : W'($urandom());
         tbl[k].t0      = (k == 0) ? 4'b1001 : TW'($urandom());
         tbl[k].e_r0    = (k == 0);
         tbl[k].e_din   = (k <= 10) ? w0[10-k] : 1'b0;
         tbl[k].e_frame = (k <= 10);
         tbl[k].e_thr   = 4'b1001;
      end

      // reset state
      model_reset();
      #1;
      chk("rst_din", din, 0);
      chk("rst_frame", frame, 0);
      chk("rst_owner", owner, 0);
      chk("rst_thr", threshold, 0);
      chk("rst_hit0", hit0, 0);
      chk("rst_hit1", hit1, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // single word on req0 from the table
      for (int k = 0; k < 13; k++) begin
         step(tbl[k].v0, tbl[k].d0, tbl[k].t0, 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);
         chk("tbl_ready", r0, tbl[k].e_r0);
         chk("tbl_din", din, tbl[k].e_din);
         chk("tbl_frame", frame, tbl[k].e_frame);
         chk("tbl_thr", threshold, tbl[k].e_thr);
      end

      // three back-to-back words from req0
      wd[0] = 11'b11100010011;
      wd[1] = 11'b11100010001;
      wd[2] = 11'b11100010010;
      exp33 = {wd[0], wd[1], wd[2]};
      idx = 0; nbits = 0; started = 1'b0; cap = '0;
      for (int c = 0; c < 45; c++) begin
         step(idx < 3, wd[(idx < 3) ? idx : 0], TW'(idx + 2), 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);
         if (r0) begin
            started = 1'b1;
            idx++;
         end
         if (started && nbits < 33) begin
            cap = {cap[31:0], din};
            chk("stream_frame", frame, 1);
            nbits++;
         end
      end
      chk("stream_words", idx, 3);
      chk("stream_bits", cap, exp33);

      // both requesters always valid
      do_reset();
      for (int c = 0; c < 50; c++) begin
         step(1'b1, W'($urandom()), 4'd3, 1'b1, W'($urandom()), 4'd12, 1'b0, 1'b0, r0, r1);
         chk("one_ready", r0 && r1, 0);
         if (r0 || r1) begin
            gq.push_back(r1 ? 1 : 0);
            chk("thr_switch", threshold, r1 ? 12 : 3);
         end
      end
      chk("grant_count", gq.size(), 5);
      foreach (gq[i]) chk("grant_order", gq[i], i % 2);

      // hit attribution and saturation
      do_reset();
      step(1'b0, '0, '0, 1'b1, 11'b10101010101, 4'd5, 1'b0, 1'b0, r0, r1);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, r0, r1);
      chk("hit1_one", hit1, 1);
      chk("hit0_zero", hit0, 0);
      for (int c = 0; c < 12; c++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);
      step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, r0, r1);
      chk("hit1_noframe", hit1, 1);
      chk("hit0_noframe", hit0, 0);
      for (int c = 0; c < 2; c++) step(1'b0, '0, '0, 1'b1, W'($urandom()), 4'd7, 1'b0, 1'b0, r0, r1);
      for (int c = 0; c < 300; c++) step(1'b0, '0, '0, 1'b1, W'($urandom()), 4'd7, 1'b1, 1'b0, r0, r1);
      chk("hit1_sat", hit1, 255);
      step(1'b0, '0, '0, 1'b1, W'($urandom()), 4'd7, 1'b1, 1'b1, r0, r1);
      chk("hit1_clr", hit1, 0);
      chk("hit0_clr", hit0, 0);
      for (int c = 0; c < 14; c++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);

      // reset mid-word after a req0 grant
      step(1'b1, 11'b11011011011, 4'd6, 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);
      for (int c = 0; c < 5; c++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);
      req0_valid = 1'b1; req1_valid = 1'b1;
      rst = 1'b0;
      #1;
      chk("mid_rst_din", din, 0);
      chk("mid_rst_frame", frame, 0);
      chk("mid_rst_owner", owner, 0);
      chk("mid_rst_thr", threshold, 0);
      chk("mid_rst_ready0", req0_ready, 0);
      chk("mid_rst_ready1", req1_ready, 0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_hold_ready0", req0_ready, 0);
      chk("rst_hold_ready1", req1_ready, 0);
      chk("rst_hold_din", din, 0);
      rst = 1'b1;
      step(1'b1, 11'b10000000001, 4'd2, 1'b1, 11'b01111111110, 4'd13, 1'b0, 1'b0, r0, r1);
      chk("rr_after_reset", r0, 1);
      for (int c = 0; c < 12; c++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, r0, r1);

      // random traffic against the model
      for (int c = 0; c < 800; c++) begin
         step(($urandom() % 3) != 0, W'($urandom()), TW'($urandom()),
              ($urandom() % 3) != 0, W'($urandom()), TW'($urandom()),
              ($urandom() % 4) == 0, ($urandom() % 50) == 0, r0, r1);
         chk("rand_one_ready", r0 && r1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
